// File: rtl/reg_bus_master.sv
// reg_bus_master
// Bus initiator for the UART register-file interface. Host commands arrive
// over a valid/ready channel, each beat becomes exactly one we or re strobe
// on the register bus, and every beat returns one response over a
// valid/ready response channel.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   cmd_valid/ready - command handshake (ready only while idle)
//   cmd_write       - 1 = write, 0 = read
//   cmd_addr        - start address
//   cmd_wdata       - write data
//   cmd_len         - read beats minus one (ignored for writes)
//   cmd_incr        - 1 = address increments per beat, 0 = fixed
//   rsp_valid/ready - response handshake
//   rsp_rdata       - captured read data (0 for writes)
//   rsp_write       - response belongs to a write
//   rsp_last        - final beat of the command
//   addr, we, re    - register-file address and strobes
//   write_data      - register-file write data
//   read_data       - register-file read data
//   busy            - high whenever a command is in progress
module reg_bus_master #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_incr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [LEN_W-1:0]  r_count;
  logic              r_incr;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rspWrite;
  logic              r_rspLast;
  logic              w_lastBeat;

  // The beat counter holds the number of beats still to issue after the
  // current one, so zero means the beat in flight is the final one.
  assign w_lastBeat = (r_count == '0);

  // Strobes are decoded from ISSUE only, so each visit to ISSUE produces
  // exactly one single-cycle strobe and a stalled response can never
  // trigger an extra register-file side effect.
  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign we         = (r_state == ISSUE) &&  r_write;
  assign re         = (r_state == ISSUE) && !r_write;
  assign addr       = r_addr;
  assign write_data = r_wdata;
  assign rsp_rdata  = r_rdata;
  assign rsp_write  = r_rspWrite;
  assign rsp_last   = r_rspLast;

  // Main sequencer: IDLE accepts a command, ISSUE drives one strobe and
  // captures the result, RESP waits for the consumer before either ending
  // the command or stepping to the next beat of a read burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_incr     <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rspWrite <= 1'b0;
      r_rspLast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            if (cmd_write) begin
              r_wdata <= cmd_wdata;
            end
            // Writes are always a single beat regardless of cmd_len.
            r_count <= cmd_write ? '0 : cmd_len;
            r_incr  <= cmd_incr;
            r_write <= cmd_write;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_rdata    <= r_write ? '0 : read_data;
          r_rspWrite <= r_write;
          r_rspLast  <= w_lastBeat;
          r_state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (w_lastBeat) begin
              r_state <= IDLE;
            end else begin
              r_count <= r_count - LEN_ONE;
              // Address arithmetic wraps naturally at the top of the space.
              if (r_incr) begin
                r_addr <= r_addr + ADDR_ONE;
              end
              r_state <= ISSUE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master
// Directed bench for reg_bus_master. A small register-file model answers
// reads with rdBase plus the number of re strobes seen since rdStart, and
// logs the address of every strobe so each scenario can check both the
// data path and the exact strobe count.
module tb_reg_bus_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_len;
  logic        cmd_incr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_last;
  logic [21:0] addr;
  logic        we;
  logic        re;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busy;

  int passCount  = 0;
  int totalCount = 0;

  int          reCount = 0;
  int          weCount = 0;
  int          rdStart = 0;
  logic [31:0] rdBase  = 32'h0;
  logic [21:0] reAddr [0:255];
  logic [21:0] lastWeAddr;
  logic [31:0] lastWeData;

  reg_bus_master #(.ADDR_W(22), .DATA_W(32), .LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_len    (cmd_len),
    .cmd_incr   (cmd_incr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_write  (rsp_write),
    .rsp_last   (rsp_last),
    .addr       (addr),
    .we         (we),
    .re         (re),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: read data advances once per re strobe.
  assign read_data = rdBase + 32'(reCount - rdStart);

  // Strobe monitor on the same edge the register file would act on.
  always @(posedge clk) begin
    if (re === 1'b1) begin
      reAddr[reCount & 255] <= addr;
      reCount <= reCount + 1;
    end
    if (we === 1'b1) begin
      weCount    <= weCount + 1;
      lastWeAddr <= addr;
      lastWeData <= write_data;
    end
  end

  // Presents one command for a single cycle; the DUT must be idle.
  task automatic sendCmd(input logic wr, input logic [21:0] a, input logic [31:0] d,
                         input logic [3:0] len, input logic inc);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_len   = len;
    cmd_incr  = inc;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits at negedges for rsp_valid; an expired bound counts as a failure.
  task automatic waitRsp(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      totalCount++;
      $display("[TB] FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    totalCount++;
    if ({cmd_ready, we, re, rsp_valid, rsp_write, rsp_last, busy} !== 7'b1000000)
      $display("[TB] FAIL reset_flags: got %b required 1000000",
               {cmd_ready, we, re, rsp_valid, rsp_write, rsp_last, busy});
    else passCount++;
    totalCount++;
    if ({addr, write_data, rsp_rdata} !== 86'h0)
      $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h required all 0", addr, write_data, rsp_rdata);
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    int weStart;
    weStart   = weCount;
    rsp_ready = 1'b0;
    sendCmd(1'b1, 22'h08, 32'h0000C001, 4'd5, 1'b0);
    totalCount++;
    if ({we, re, busy, cmd_ready} !== 4'b1010)
      $display("[TB] FAIL write_strobe: we/re/busy/cmd_ready=%b required 1010", {we, re, busy, cmd_ready});
    else passCount++;
    totalCount++;
    if (addr !== 22'h08 || write_data !== 32'h0000C001)
      $display("[TB] FAIL write_bus: addr=%h wdata=%h required 000008 0000c001", addr, write_data);
    else passCount++;
    @(negedge clk);
    totalCount++;
    if ({rsp_valid, rsp_write, rsp_last, we} !== 4'b1110 || rsp_rdata !== 32'h0)
      $display("[TB] FAIL write_rsp: valid/write/last/we=%b rdata=%h required 1110 00000000",
               {rsp_valid, rsp_write, rsp_last, we}, rsp_rdata);
    else passCount++;
    // Held response: nothing changes while the consumer stalls.
    @(negedge clk);
    totalCount++;
    if ({rsp_valid, we} !== 2'b10)
      $display("[TB] FAIL write_hold: valid/we=%b required 10", {rsp_valid, we});
    else passCount++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    totalCount++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100)
      $display("[TB] FAIL write_idle: cmd_ready/busy/rsp_valid=%b required 100", {cmd_ready, busy, rsp_valid});
    else passCount++;
    totalCount++;
    if (weCount - weStart !== 1 || lastWeAddr !== 22'h08 || lastWeData !== 32'h0000C001)
      $display("[TB] FAIL write_count: we_cycles=%0d addr=%h data=%h required 1 000008 0000c001",
               weCount - weStart, lastWeAddr, lastWeData);
    else passCount++;
  endtask

  task automatic test_read();
    int reStart;
    bit ok;
    reStart   = reCount;
    rdStart   = reCount;
    rdBase    = 32'h00000005;
    rsp_ready = 1'b0;
    sendCmd(1'b0, 22'h01, 32'hDEADBEEF, 4'd0, 1'b0);
    totalCount++;
    if ({we, re} !== 2'b01 || addr !== 22'h01 || write_data !== 32'h0000C001)
      $display("[TB] FAIL read_strobe: we/re=%b addr=%h wdata=%h required 01 000001 0000c001",
               {we, re}, addr, write_data);
    else passCount++;
    waitRsp("read", ok);
    if (!ok) return;
    totalCount++;
    if (rsp_rdata !== 32'h5 || {rsp_last, rsp_write, busy} !== 3'b101)
      $display("[TB] FAIL read_rsp: rdata=%h last/write/busy=%b required 00000005 101",
               rsp_rdata, {rsp_last, rsp_write, busy});
    else passCount++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    totalCount++;
    if (busy !== 1'b0 || reCount - reStart !== 1)
      $display("[TB] FAIL read_done: busy=%b re_cycles=%0d required 0 1", busy, reCount - reStart);
    else passCount++;
  endtask

  task automatic test_burst();
    int reStart;
    bit ok;
    reStart   = reCount;
    rdStart   = reCount;
    rdBase    = 32'hA1;
    rsp_ready = 1'b1;
    sendCmd(1'b0, 22'h0F, 32'h0, 4'd3, 1'b0);
    for (int b = 0; b < 4; b++) begin
      waitRsp("burst", ok);
      if (!ok) begin
        rsp_ready = 1'b0;
        return;
      end
      totalCount++;
      if (rsp_rdata !== 32'hA1 + 32'(b) || rsp_last !== (b == 3))
        $display("[TB] FAIL burst_beat%0d: rdata=%h last=%b required %h %b",
                 b, rsp_rdata, rsp_last, 32'hA1 + 32'(b), (b == 3));
      else passCount++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    totalCount++;
    if (reCount - reStart !== 4 || busy !== 1'b0)
      $display("[TB] FAIL burst_count: re_cycles=%0d busy=%b required 4 0", reCount - reStart, busy);
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      totalCount++;
      if (reAddr[(reStart + i) & 255] !== 22'h0F)
        $display("[TB] FAIL burst_addr%0d: addr=%h required 00000f", i, reAddr[(reStart + i) & 255]);
      else passCount++;
    end
  endtask

  task automatic test_backpressure();
    int reStart;
    int reHold;
    bit ok;
    reStart   = reCount;
    rdStart   = reCount;
    rdBase    = 32'hA1;
    rsp_ready = 1'b0;
    sendCmd(1'b0, 22'h0F, 32'h0, 4'd3, 1'b0);
    for (int b = 0; b < 4; b++) begin
      waitRsp("stall", ok);
      if (!ok) return;
      totalCount++;
      if (rsp_rdata !== 32'hA1 + 32'(b) || rsp_last !== (b == 3))
        $display("[TB] FAIL stall_beat%0d: rdata=%h last=%b required %h %b",
                 b, rsp_rdata, rsp_last, 32'hA1 + 32'(b), (b == 3));
      else passCount++;
      if (b == 1) begin
        reHold = reCount;
        repeat (5) @(negedge clk);
        totalCount++;
        if (reCount !== reHold || rsp_rdata !== 32'hA2 || rsp_valid !== 1'b1 || re !== 1'b0)
          $display("[TB] FAIL stall_hold: re_during_stall=%0d rdata=%h valid=%b required 0 000000a2 1",
                   reCount - reHold, rsp_rdata, rsp_valid);
        else passCount++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    repeat (2) @(negedge clk);
    totalCount++;
    if (reCount - reStart !== 4 || cmd_ready !== 1'b1)
      $display("[TB] FAIL stall_count: re_cycles=%0d cmd_ready=%b required 4 1", reCount - reStart, cmd_ready);
    else passCount++;
  endtask

  task automatic test_wrap();
    int reStart;
    bit ok;
    reStart   = reCount;
    rdStart   = reCount;
    rdBase    = 32'h300;
    rsp_ready = 1'b1;
    sendCmd(1'b0, 22'h3FFFFF, 32'h0, 4'd1, 1'b1);
    for (int b = 0; b < 2; b++) begin
      waitRsp("wrap", ok);
      if (!ok) begin
        rsp_ready = 1'b0;
        return;
      end
      totalCount++;
      if (rsp_rdata !== 32'h300 + 32'(b) || rsp_last !== (b == 1))
        $display("[TB] FAIL wrap_beat%0d: rdata=%h last=%b required %h %b",
                 b, rsp_rdata, rsp_last, 32'h300 + 32'(b), (b == 1));
      else passCount++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    totalCount++;
    if (reCount - reStart !== 2 || reAddr[reStart & 255] !== 22'h3FFFFF || reAddr[(reStart + 1) & 255] !== 22'h0)
      $display("[TB] FAIL wrap_addr: re_cycles=%0d addr0=%h addr1=%h required 2 3fffff 000000",
               reCount - reStart, reAddr[reStart & 255], reAddr[(reStart + 1) & 255]);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int reStart;
    bit ok;
    reStart   = reCount;
    rdStart   = reCount;
    rdBase    = 32'hB0;
    rsp_ready = 1'b0;
    sendCmd(1'b0, 22'h30, 32'h0, 4'd3, 1'b1);
    waitRsp("rstmid_b0", ok);
    if (!ok) return;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    waitRsp("rstmid_b1", ok);
    if (!ok) return;
    totalCount++;
    if (rsp_rdata !== 32'hB1 || addr !== 22'h31)
      $display("[TB] FAIL rstmid_beat1: rdata=%h addr=%h required 000000b1 000031", rsp_rdata, addr);
    else passCount++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    totalCount++;
    if ({cmd_ready, rsp_valid, busy, re} !== 4'b1000)
      $display("[TB] FAIL rstmid_idle: cmd_ready/rsp_valid/busy/re=%b required 1000",
               {cmd_ready, rsp_valid, busy, re});
    else passCount++;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0;
    totalCount++;
    if (reCount - reStart !== 2 || rsp_valid !== 1'b0)
      $display("[TB] FAIL rstmid_abandon: re_cycles=%0d rsp_valid=%b required 2 0", reCount - reStart, rsp_valid);
    else passCount++;
    // A fresh command after the abandoned burst must run normally.
    reStart = reCount;
    rdStart = reCount;
    rdBase  = 32'h77;
    sendCmd(1'b0, 22'h05, 32'h0, 4'd0, 1'b0);
    waitRsp("rstmid_fresh", ok);
    if (!ok) return;
    totalCount++;
    if (rsp_rdata !== 32'h77 || rsp_last !== 1'b1 || reAddr[reStart & 255] !== 22'h05)
      $display("[TB] FAIL rstmid_fresh: rdata=%h last=%b addr=%h required 00000077 1 000005",
               rsp_rdata, rsp_last, reAddr[reStart & 255]);
    else passCount++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    totalCount++;
    if (cmd_ready !== 1'b1 || reCount - reStart !== 1)
      $display("[TB] FAIL rstmid_fresh_done: cmd_ready=%b re_cycles=%0d required 1 1", cmd_ready, reCount - reStart);
    else passCount++;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_len   = '0;
    cmd_incr  = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
Bus initiator for the UART register-file interface (addr/we/re/write_data/read_data). It accepts command transactions from a host-side source (bridge, sequencer or soft CPU) over a valid/ready handshake. Each command becomes exactly one we or re strobe per beat; the captured read data is returned over a valid/ready response channel. Read bursts let one command drain RDRn or scan a register range. Exact strobe counts matter because every re cycle on SRn/RDRn has side effects in the UART channels.

Parameters:
ADDR_W, 22, register address width
DATA_W, 32, data width
LEN_W, 4, burst length field width (beats = cmd_len+1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  start address
cmd_wdata  input  DATA_W  write data
cmd_len  input  LEN_W  read beats minus one; ignored for writes
cmd_incr  input  1  1 = address +1 per beat, 0 = fixed address
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_rdata  output  DATA_W  captured read data (0 for writes)
rsp_write  output  1  response belongs to a write
rsp_last  output  1  final beat of the command
addr  output  ADDR_W  register address to register file
we  output  1  write strobe
re  output  1  read strobe
write_data  output  DATA_W  write data to register file
read_data  input  DATA_W  read data from register file
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: clk and a synchronous, active-high rst. On a clk edge with rst=1 the state becomes IDLE. Outputs: cmd_ready=1, we=0, re=0, addr=0, write_data=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_last=0, busy=0. The beat counter is cleared. rst overrides every other event. A reset mid-burst abandons the command: no further strobes and no response.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered or decoded from state.
- IDLE: cmd_ready=1. A command is accepted on an edge with cmd_valid&cmd_ready. At acceptance:
  - addr<=cmd_addr.
  - write_data<=cmd_wdata for writes; write_data is held otherwise.
  - The beat counter loads cmd_len for reads or 0 for writes.
  - incr and write flags are latched.
  - The state goes to ISSUE.
- ISSUE: lasts exactly one cycle. we=1 for a write, re=1 for a read. The other strobe is 0. Strobes are never asserted outside ISSUE.
  - At the closing edge: rsp_rdata<=read_data for reads or 0 for writes; rsp_write<=write flag; rsp_last<=(counter==0). The state goes to RESP.
- RESP: rsp_valid=1, and the strobes are low. The block holds rsp_* stable until rsp_valid&rsp_ready.
  - On handshake with counter==0: go to IDLE.
  - On handshake with counter!=0: counter-1; addr<=addr+1 if incr (modulo 2^ADDR_W, so 0x3FFFFF wraps to 0x000000); go to ISSUE.
- Latency: command accepted at edge T; we/re high in cycle T..T+1; rsp_valid high from edge T+1. With rsp_ready held high, a read burst of N beats issues one strobe every 2 cycles. A new command can be accepted one cycle after the last handshake.
- Backpressure: while rsp_ready=0, no new strobe is issued. Strobe count always equals beats consumed.
- cmd_valid in a non-IDLE state is ignored (cmd_ready=0). The command is not lost by the source because the handshake has not occurred.
- addr and write_data hold their last values in IDLE and RESP. Only we and re qualify them.

Test Plan:
- Write cmd addr=0x08, wdata=0x0000C001 -> exactly one we cycle with addr=0x08, write_data=0x0000C001. The response has rsp_write=1, rsp_last=1, rsp_rdata=0.
- Read addr=0x01 with model read_data=0x00000005 -> one re cycle at addr 0x01; rsp_rdata=0x5, rsp_last=1, busy drops one cycle after the handshake.
- Read burst addr=0x0F, len=3, incr=0, model returning 0xA1..0xA4 per re -> 4 single-cycle re pulses, all at addr 0x0F. Responses are 0xA1..0xA4, with rsp_last only on the 4th.
- Same burst with rsp_ready low for 5 cycles after beat 2 -> no re during the stall; rsp_rdata is held at 0xA2; total re count is still 4.
- Read burst addr=0x3FFFFF, len=1, incr=1 -> re at 0x3FFFFF, then at 0x000000.
- Assert rst for one cycle during RESP of beat 2 of a 4-beat burst -> next cycle IDLE, cmd_ready=1, rsp_valid=0; no further re; a fresh command then completes normally.
